// File: rtl/tcu_microcode_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// tcu_microcode_arbiter_pkg : shared state encodings and response codes
// Revision 1.0
// ============================================================================
package tcu_microcode_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_RELEASE = 2'd2,
        ARB_RSVD    = 2'd3
    } arb_state_e;

    localparam int DEF_WORD_W      = 32;
    localparam int DEF_WDOG_CYCLES = 4096;

    // Response code packs {timeout, error}.
    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_ERROR   = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/tcu_microcode_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// rr_priority_picker : combinational round-robin search from a start pointer
// Revision 1.0
// ============================================================================
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    function automatic int wrap_idx(input int base, input int ofs);
        return (base + ofs >= N) ? (base + ofs - N) : (base + ofs);
    endfunction

    logic [IW-1:0] w_k;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        w_k       = '0;
        for (int i = 0; i < N; i++) begin
            w_k = IW'(wrap_idx(int'(ptr), i));
            if (!any_valid && req[w_k]) begin
                any_valid  = 1'b1;
                grant[w_k] = 1'b1;
                idx        = w_k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcu_microcode_arbiter.sv
`default_nettype none
// ============================================================================
// tcu_microcode_arbiter : round-robin sharing of the TCU microcode port
// Revision 1.0
// ============================================================================
module tcu_microcode_arbiter
    import tcu_microcode_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        cfg_req_mask,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [4*NUM_REQ-1:0]      req_op,
    input  logic [WORD_W*NUM_REQ-1:0] req_a,
    input  logic [WORD_W*NUM_REQ-1:0] req_b,
    input  logic [WORD_W*NUM_REQ-1:0] req_c,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_error,
    output logic                      rsp_timeout,
    output logic [WORD_W-1:0]         rsp_result,
    output logic                      mc_enable,
    output logic [3:0]                mc_operation,
    output logic [WORD_W-1:0]         mc_operand_a,
    output logic [WORD_W-1:0]         mc_operand_b,
    output logic [WORD_W-1:0]         mc_operand_c,
    input  logic [WORD_W-1:0]         mc_result,
    input  logic                      mc_valid,
    input  logic                      mc_ready,
    input  logic                      mc_error,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [1:0]                arb_state,
    output logic [15:0]               timeout_count
);

    localparam int TMR_W = $clog2(WDOG_CYCLES) + 1;

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic [NUM_REQ-1:0]  accept_q, accept_d;
    logic [NUM_REQ-1:0]  rspv_q, rspv_d;
    logic [1:0]          rsp_code_q, rsp_code_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                en_q, en_d;
    logic [3:0]          op_q, op_d;
    logic [WORD_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic [NUM_REQ-1:0]  w_grant_onehot;

    assign w_eligible     = req_valid & cfg_req_mask;
    assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_picker (
        .req       (w_eligible),
        .ptr       (rr_ptr_q),
        .grant     (w_pick_onehot),
        .idx       (w_pick_idx),
        .any_valid (w_pick_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        timer_d    = timer_q;
        tcnt_d     = tcnt_q;
        accept_d   = '0;
        rspv_d     = '0;
        rsp_code_d = RSP_OK;
        result_d   = result_q;
        en_d       = 1'b0;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        case (state_q)
            ARB_IDLE: begin
                // A downstream still presenting a stale valid must drain first.
                if (w_pick_any && mc_ready && !mc_valid) begin
                    accept_d   = w_pick_onehot;
                    op_d       = req_op[int'(w_pick_idx)*4 +: 4];
                    a_d        = req_a[int'(w_pick_idx)*WORD_W +: WORD_W];
                    b_d        = req_b[int'(w_pick_idx)*WORD_W +: WORD_W];
                    c_d        = req_c[int'(w_pick_idx)*WORD_W +: WORD_W];
                    en_d       = 1'b1;
                    grant_id_d = w_pick_idx;
                    rr_ptr_d   = (w_pick_idx == ID_W'(NUM_REQ-1)) ? '0 : w_pick_idx + 1'b1;
                    timer_d    = '0;
                    state_d    = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                en_d    = 1'b1;
                timer_d = timer_q + 1'b1;
                if (mc_error) begin
                    rspv_d     = w_grant_onehot;
                    rsp_code_d = RSP_ERROR;
                    en_d       = 1'b0;
                    state_d    = ARB_RELEASE;
                end else if (mc_valid) begin
                    rspv_d   = w_grant_onehot;
                    result_d = mc_result;
                    en_d     = 1'b0;
                    state_d  = ARB_RELEASE;
                end else if (timer_q == TMR_W'(WDOG_CYCLES-1)) begin
                    rspv_d     = w_grant_onehot;
                    rsp_code_d = RSP_TIMEOUT;
                    en_d       = 1'b0;
                    state_d    = ARB_RELEASE;
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            ARB_RELEASE: begin
                if (mc_ready && !mc_valid && !mc_error) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            timer_q    <= '0;
            tcnt_q     <= '0;
            accept_q   <= '0;
            rspv_q     <= '0;
            rsp_code_q <= RSP_OK;
            result_q   <= '0;
            en_q       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            timer_q    <= timer_d;
            tcnt_q     <= tcnt_d;
            accept_q   <= accept_d;
            rspv_q     <= rspv_d;
            rsp_code_q <= rsp_code_d;
            result_q   <= result_d;
            en_q       <= en_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
        end
    end

    assign req_accept    = accept_q;
    assign rsp_valid     = rspv_q;
    assign rsp_error     = rsp_code_q[0];
    assign rsp_timeout   = rsp_code_q[1];
    assign rsp_result    = result_q;
    assign mc_enable     = en_q;
    assign mc_operation  = op_q;
    assign mc_operand_a  = a_q;
    assign mc_operand_b  = b_q;
    assign mc_operand_c  = c_q;
    assign busy          = (state_q != ARB_IDLE);
    assign grant_id      = grant_id_q;
    assign arb_state     = state_q;
    assign timeout_count = tcnt_q;

endmodule
`default_nettype wire

// File: doc/tcu_microcode_arbiter.md
Name: tcu_microcode_arbiter

Overview:
- Shares the single microcode port of the enhanced TCU interface among NUM_REQ microcode requesters (sequencer threads, vector unit, debug).
- Arbitrates round-robin under a per-requester enable mask and forwards one operation at a time.
- Runs the downstream enable/valid/ready handshake and returns the result or error to the granted requester.
- Has its own watchdog, so a hung downstream cannot block all requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index (clog2(NUM_REQ)).
- WORD_W, `VTX1_WORD_WIDTH, operand/result width.
- WDOG_CYCLES, 4096, maximum cycles in WAIT before a forced timeout.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_req_mask  in  NUM_REQ  1 = requester eligible for grant.
- req_valid  in  NUM_REQ  request pending; held with its payload until req_accept.
- req_op  in  4*NUM_REQ  packed 4-bit operation code per requester.
- req_a, req_b, req_c  in  WORD_W*NUM_REQ  packed operands.
- req_accept  out  NUM_REQ  one-cycle one-hot pulse; payload captured.
- rsp_valid  out  NUM_REQ  one-cycle one-hot completion pulse; no backpressure.
- rsp_error  out  1  qualifies rsp_valid: operation failed.
- rsp_timeout  out  1  qualifies rsp_valid: the error is a watchdog timeout.
- rsp_result  out  WORD_W  result; valid with rsp_valid and no error.
- mc_enable  out  1  to microcode_enable.
- mc_operation  out  4  to microcode_operation.
- mc_operand_a/b/c  out  WORD_W each  to microcode_operand_a/b/c.
- mc_result  in  WORD_W  from microcode_result.
- mc_valid, mc_ready, mc_error  in  1 each  from the enhanced interface.
- busy  out  1  arbiter not in IDLE.
- grant_id  out  ID_W  index of the current or last granted requester.
- arb_state  out  2  current state encoding.
- timeout_count  out  16  saturating count of watchdog events.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including mc_enable, req_accept, rsp_* and counters; rr_ptr=0; captured payload=0. Asserting rst mid-operation drops mc_enable immediately. No response is ever produced for an aborted operation.
- Eligible set = req_valid & cfg_req_mask.
- States: IDLE=0, WAIT=1, RELEASE=2. Value 3 is unused and recovers to IDLE with mc_enable=0.
- IDLE:
  - Grant only if eligible set is non-zero AND mc_ready=1 AND mc_valid=0.
  - Winner g = first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Same edge: req_accept[g]<=1 for one cycle; mc_operation/operands <= payload of g; mc_enable<=1; grant_id<=g; rr_ptr<=(g+1) mod NUM_REQ; timer<=0; next state WAIT.
- WAIT (mc_enable held 1, operands stable, timer increments each cycle):
  - mc_error=1, including when mc_valid=1 in the same cycle (error wins): rsp_valid[grant_id] pulse, rsp_error=1, rsp_timeout=0.
  - Else mc_valid=1: rsp_valid pulse, rsp_result<=mc_result, rsp_error=0.
  - Else timer==WDOG_CYCLES-1: rsp_valid pulse, rsp_error=1, rsp_timeout=1, timeout_count+1 (saturates at 16'hFFFF).
  - Every exit: mc_enable<=0; next state RELEASE.
  - Latency: rsp_valid is asserted on the clock edge after mc_valid/mc_error is first sampled high.
- RELEASE (mc_enable=0): go to IDLE once mc_ready=1 and mc_valid=0 and mc_error=0. Stay otherwise, with no watchdog. No new grant is issued in the same cycle; the earliest next req_accept is one cycle after entering IDLE.
- A requester that drops req_valid before acceptance is never granted and never gets a response.
- cfg_req_mask changes take effect at the next IDLE evaluation; they never abort an in-flight operation.
- mc_ready low in IDLE blocks all grants. Pending requests wait indefinitely; no starvation, since rr_ptr advances only on grant.
- rsp_result holds its value until the next successful response. rsp_error and rsp_timeout are 0 whenever rsp_valid=0.
- busy = (state != IDLE).

Decomposition:
- Shared package/header vtx1_arb_constants.v: state encodings ARB_IDLE/ARB_WAIT/ARB_RELEASE, default WDOG_CYCLES, rsp error-code constants.
- Sub-module rr_priority_picker (parameter N): combinational round-robin search. Inputs request vector and pointer; outputs one-hot grant, index and any_valid. It is reused by later arbiters.

Test Plan:
- Single request: req_valid[1]=1, op=4'h0, a=5, b=7; downstream answers mc_valid with mc_result=12 after 3 cycles -> req_accept=4'b0010 pulse; mc_enable high for 4 cycles; rsp_valid=4'b0010 with rsp_result=12, rsp_error=0.
- Fairness: all four req_valid held high with cfg_req_mask=4'hF -> grant order 0,1,2,3,0 over five operations.
- Mask: cfg_req_mask=4'b1011 with all requests high -> requester 2 is never accepted.
- Error precedence: mc_error=1 and mc_valid=1 in the same cycle -> rsp_error=1, rsp_result unchanged from its previous value.
- Watchdog: WDOG_CYCLES=16, downstream silent -> rsp_valid with rsp_error=1 and rsp_timeout=1 exactly 16 cycles after req_accept; timeout_count=1; arbiter stays in RELEASE until mc_ready=1.
- Reset mid-WAIT: assert rst -> mc_enable=0 and busy=0 asynchronously; no rsp_valid; after release, the first grant goes to requester 0.
